// File: rtl/canal_pkg.sv
// Shared types for the canal lock scheduler: controller states and lock sides.
package canal_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PREP        = 3'd1,
      OPEN_ENTRY  = 3'd2,
      CLOSE_ENTRY = 3'd3,
      TRANSFER    = 3'd4,
      OPEN_EXIT   = 3'd5,
      CLOSE_EXIT  = 3'd6
   } lock_state_t;

   typedef enum logic {
      SIDE_LOW  = 1'b0,
      SIDE_HIGH = 1'b1
   } side_t;

   function automatic side_t other_side(input side_t s);
      return (s == SIDE_LOW) ? SIDE_HIGH : SIDE_LOW;
   endfunction

endpackage

// File: rtl/canal_lock_scheduler_if.sv
// Ship-side handshake and lock command bus of the canal lock scheduler.
interface canal_lock_scheduler_if #(parameter int LW = 3);
   logic          req_low;
   logic          req_high;
   logic          ship_in;
   logic          ship_out;
   logic          grant_low;
   logic          grant_high;
   logic          gate_low_open;
   logic          gate_high_open;
   logic          fill;
   logic          drain;
   logic [LW-1:0] level;
   logic          busy;

   modport master (
      output req_low, req_high, ship_in, ship_out,
      input  grant_low, grant_high, gate_low_open, gate_high_open,
             fill, drain, level, busy
   );

   modport slave (
      input  req_low, req_high, ship_in, ship_out,
      output grant_low, grant_high, gate_low_open, gate_high_open,
             fill, drain, level, busy
   );
endinterface

// File: rtl/canal_lock_scheduler_checker.sv
// Safety interlock properties of the canal lock outputs.
module canal_lock_scheduler_checker #(
   parameter int LEVEL_MAX = 7,
   parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
   input logic          clk,
   input logic          reset_n,
   input logic          gate_low_open,
   input logic          gate_high_open,
   input logic          fill,
   input logic          drain,
   input logic [LW-1:0] level
);
   localparam logic [LW-1:0] LVL_TOP = LW'(LEVEL_MAX);
   localparam logic [LW-1:0] LVL_BOT = {LW{1'b0}};

   a_gates_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      !(gate_low_open && gate_high_open));
   a_gate_no_pump: assert property (@(posedge clk) disable iff (!reset_n)
      !((gate_low_open || gate_high_open) && (fill || drain)));
   a_pumps_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
      !(fill && drain));
   a_fill_saturates: assert property (@(posedge clk) disable iff (!reset_n)
      !(fill && (level == LVL_TOP)));
   a_drain_saturates: assert property (@(posedge clk) disable iff (!reset_n)
      !(drain && (level == LVL_BOT)));
endmodule

// File: rtl/canal_lock_scheduler_water_level_counter.sv
// Saturating up/down counter holding the chamber water level (0 .. LEVEL_MAX).
module water_level_counter #(
   parameter int LEVEL_MAX = 7,
   parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          fill,
   input  logic          drain,
   output logic [LW-1:0] level
);
   localparam logic [LW-1:0] LVL_TOP = LW'(LEVEL_MAX);
   localparam logic [LW-1:0] LVL_BOT = {LW{1'b0}};
   localparam logic [LW-1:0] ONE     = LW'(1);

   logic [LW-1:0] level_r;

   // One step per cycle, never past either end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_r <= LVL_BOT;
      end else if (fill && !drain && (level_r != LVL_TOP)) begin
         level_r <= level_r + ONE;
      end else if (drain && !fill && (level_r != LVL_BOT)) begin
         level_r <= level_r - ONE;
      end else begin
         level_r <= level_r;
      end
   end

   assign level = level_r;
endmodule

// File: rtl/canal_lock_scheduler.sv
// Canal lock controller: round-robin side arbitration, level matching, gate sequencing.
module canal_lock_scheduler
   import canal_pkg::*;
#(
   parameter int LEVEL_MAX = 7,
   parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
   input logic                  clk,
   input logic                  reset_n,
   canal_lock_scheduler_if.slave bus
);
   localparam logic [LW-1:0] LVL_TOP = LW'(LEVEL_MAX);
   localparam logic [LW-1:0] LVL_BOT = {LW{1'b0}};
   localparam logic [LW-1:0] ONE     = LW'(1);

   lock_state_t   state_r, state_n_s;
   side_t         side_r, side_n_s, last_r;
   logic [LW-1:0] level_s, level_n_s, entry_lvl_s, exit_lvl_s, target_s;
   logic          grant_low_r, grant_high_r, gate_low_r, gate_high_r;
   logic          fill_r, drain_r, busy_r;
   logic          pumping_s, fill_n_s, drain_n_s, gate_low_n_s, gate_high_n_s;

   water_level_counter #(.LEVEL_MAX(LEVEL_MAX), .LW(LW)) u_level (
      .clk(clk), .reset_n(reset_n), .fill(fill_r), .drain(drain_r), .level(level_s)
   );

   // Level the counter will hold after the coming edge, so outputs can be registered
   always_comb begin
      level_n_s = level_s;
      if (fill_r && !drain_r && (level_s != LVL_TOP)) begin
         level_n_s = level_s + ONE;
      end else if (drain_r && !fill_r && (level_s != LVL_BOT)) begin
         level_n_s = level_s - ONE;
      end else begin
         level_n_s = level_s;
      end
   end

   // Arbitration and next-state decode
   always_comb begin
      side_n_s  = side_r;
      state_n_s = state_r;
      if (state_r == IDLE) begin
         if (bus.req_low && bus.req_high) begin
            side_n_s = other_side(last_r);
         end else if (bus.req_low) begin
            side_n_s = SIDE_LOW;
         end else if (bus.req_high) begin
            side_n_s = SIDE_HIGH;
         end else begin
            side_n_s = side_r;
         end
      end else begin
         side_n_s = side_r;
      end
      entry_lvl_s = (side_n_s == SIDE_LOW) ? LVL_BOT : LVL_TOP;
      exit_lvl_s  = (side_n_s == SIDE_LOW) ? LVL_TOP : LVL_BOT;
      case (state_r)
         IDLE:        state_n_s = (bus.req_low || bus.req_high) ? PREP : IDLE;
         PREP:        state_n_s = (level_n_s == entry_lvl_s) ? OPEN_ENTRY : PREP;
         OPEN_ENTRY:  state_n_s = bus.ship_in ? CLOSE_ENTRY : OPEN_ENTRY;
         CLOSE_ENTRY: state_n_s = TRANSFER;
         TRANSFER:    state_n_s = (level_n_s == exit_lvl_s) ? OPEN_EXIT : TRANSFER;
         OPEN_EXIT:   state_n_s = bus.ship_out ? CLOSE_EXIT : OPEN_EXIT;
         CLOSE_EXIT:  state_n_s = IDLE;
         default:     state_n_s = IDLE;
      endcase
   end

   // Output values for the state being entered
   always_comb begin
      pumping_s     = (state_n_s == PREP) || (state_n_s == TRANSFER);
      target_s      = (state_n_s == PREP) ? entry_lvl_s : exit_lvl_s;
      fill_n_s      = pumping_s && (level_n_s < target_s);
      drain_n_s     = pumping_s && (level_n_s > target_s);
      gate_low_n_s  = ((state_n_s == OPEN_ENTRY) && (side_n_s == SIDE_LOW)) ||
                      ((state_n_s == OPEN_EXIT)  && (side_n_s == SIDE_HIGH));
      gate_high_n_s = ((state_n_s == OPEN_ENTRY) && (side_n_s == SIDE_HIGH)) ||
                      ((state_n_s == OPEN_EXIT)  && (side_n_s == SIDE_LOW));
   end

   // Controller state and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         side_r       <= SIDE_LOW;
         last_r       <= SIDE_HIGH;
         grant_low_r  <= 1'b0;
         grant_high_r <= 1'b0;
         gate_low_r   <= 1'b0;
         gate_high_r  <= 1'b0;
         fill_r       <= 1'b0;
         drain_r      <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         side_r       <= side_n_s;
         last_r       <= (state_r == CLOSE_EXIT) ? side_r : last_r;
         grant_low_r  <= (state_r == IDLE) && (state_n_s == PREP) && (side_n_s == SIDE_LOW);
         grant_high_r <= (state_r == IDLE) && (state_n_s == PREP) && (side_n_s == SIDE_HIGH);
         gate_low_r   <= gate_low_n_s;
         gate_high_r  <= gate_high_n_s;
         fill_r       <= fill_n_s;
         drain_r      <= drain_n_s;
         busy_r       <= (state_n_s != IDLE);
      end
   end

   assign bus.grant_low      = grant_low_r;
   assign bus.grant_high     = grant_high_r;
   assign bus.gate_low_open  = gate_low_r;
   assign bus.gate_high_open = gate_high_r;
   assign bus.fill           = fill_r;
   assign bus.drain          = drain_r;
   assign bus.level          = level_s;
   assign bus.busy           = busy_r;
endmodule

// File: tb/tb_canal_lock_scheduler.sv
// Randomized trip-level bench for canal_lock_scheduler with a per-cycle output scoreboard.
module tb_canal_lock_scheduler;
   import canal_pkg::*;

   localparam int LEVEL_MAX = 7;
   localparam int LW        = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   canal_lock_scheduler_if #(.LW(LW)) bus ();

   canal_lock_scheduler #(.LEVEL_MAX(LEVEL_MAX), .LW(LW)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   canal_lock_scheduler_checker #(.LEVEL_MAX(LEVEL_MAX), .LW(LW)) u_chk (
      .clk(clk), .reset_n(reset_n),
      .gate_low_open(bus.gate_low_open), .gate_high_open(bus.gate_high_open),
      .fill(bus.fill), .drain(bus.drain), .level(bus.level)
   );

   typedef struct packed {
      logic gl, gh, ol, oh, f, d;
      logic [LW-1:0] lvl;
      logic busy;
   } exp_t;

   exp_t  exp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    fill_seen = 0;
   int    m_level;
   side_t m_last;
   bit    held_low, held_high;

   function automatic exp_t mk(bit gl, bit gh, bit ol, bit oh, bit f, bit d, int lvl, bit b);
      exp_t e;
      e.gl = gl; e.gh = gh; e.ol = ol; e.oh = oh; e.f = f; e.d = d;
      e.lvl = LW'(lvl); e.busy = b;
      return e;
   endfunction

   function automatic bit coin(int pct);
      return $urandom_range(99, 0) < pct;
   endfunction

   task automatic chk(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One clock of stimulus plus the outputs expected after the edge that samples it
   task automatic cyc(bit rl, bit rh, bit si, bit so, exp_t e);
      @(negedge clk);
      bus.req_low = rl; bus.req_high = rh; bus.ship_in = si; bus.ship_out = so;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && bus.fill) fill_seen++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.grant_low, bus.grant_high, bus.gate_low_open, bus.gate_high_open,
                 bus.fill, bus.drain, bus.level, bus.busy};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs @%0t: actual gl=%b gh=%b ol=%b oh=%b fill=%b drain=%b level=%0d busy=%b required gl=%b gh=%b ol=%b oh=%b fill=%b drain=%b level=%0d busy=%b",
                        $time, a.gl, a.gh, a.ol, a.oh, a.f, a.d, a.lvl, a.busy,
                        e.gl, e.gh, e.ol, e.oh, e.f, e.d, e.lvl, e.busy);
            end
         end
      end
   end

   // One ship passage: idle gap, grant, level match, entry, transfer, exit, one idle cycle
   task automatic trip(int gap, bit new_low, bit new_high, int w_in, int w_out, int noise,
                       bit abort_exit, output side_t granted, output int ncalls);
      int L, E, X, d, lvl, rn;
      bit rl, rh, gl, gh;
      L = m_level;
      ncalls = 0;
      rn = noise / 3;
      if (held_low || held_high) gap = 0;
      for (int i = 0; i < gap; i++)
         cyc(1'b0, 1'b0, coin(noise), coin(noise), mk(0, 0, 0, 0, 0, 0, L, 0));
      rl = held_low | new_low;
      rh = held_high | new_high;
      if (rl && rh) granted = (m_last == SIDE_LOW) ? SIDE_HIGH : SIDE_LOW;
      else          granted = rl ? SIDE_LOW : SIDE_HIGH;
      gl = (granted == SIDE_LOW);
      gh = !gl;
      E = gl ? 0 : LEVEL_MAX;
      X = LEVEL_MAX - E;
      held_low  = rl && !gl && coin(50);
      held_high = rh && gl && coin(50);
      d = (E > L) ? E - L : L - E;
      if (d == 0) begin
         cyc(rl, rh, coin(noise), coin(noise), mk(gl, gh, 0, 0, 0, 0, L, 1));
         ncalls++;
      end else begin
         for (int p = 0; p < d; p++) begin
            lvl = (E > L) ? L + p : L - p;
            if (p == 0) cyc(rl, rh, coin(noise), coin(noise), mk(gl, gh, 0, 0, E > L, E < L, lvl, 1));
            else        cyc(held_low | coin(rn), held_high | coin(rn), coin(noise), coin(noise),
                            mk(0, 0, 0, 0, E > L, E < L, lvl, 1));
            ncalls++;
         end
      end
      for (int i = 0; i < w_in; i++) begin
         cyc(held_low | coin(rn), held_high | coin(rn), (i == 0) ? coin(noise) : 1'b0, coin(noise),
             mk(0, 0, gl, gh, 0, 0, E, 1));
         ncalls++;
      end
      cyc(held_low | coin(rn), held_high | coin(rn), 1'b1, coin(noise), mk(0, 0, 0, 0, 0, 0, E, 1));
      ncalls++;
      for (int p = 0; p < LEVEL_MAX; p++) begin
         lvl = (X > E) ? E + p : E - p;
         cyc(held_low | coin(rn), held_high | coin(rn), coin(noise), coin(noise),
             mk(0, 0, 0, 0, X > E, X < E, lvl, 1));
         ncalls++;
      end
      for (int i = 0; i < w_out; i++) begin
         cyc(held_low | coin(rn), held_high | coin(rn), coin(noise), (i == 0) ? coin(noise) : 1'b0,
             mk(0, 0, gh, gl, 0, 0, X, 1));
         ncalls++;
         if (abort_exit) return;
      end
      cyc(held_low | coin(rn), held_high | coin(rn), coin(noise), 1'b1, mk(0, 0, 0, 0, 0, 0, X, 1));
      cyc(held_low | coin(rn), held_high | coin(rn), coin(noise), coin(noise), mk(0, 0, 0, 0, 0, 0, X, 0));
      ncalls += 2;
      m_level = X;
      m_last  = granted;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      side_t g;
      int    n, f0, r;
      bus.req_low = 1'b0; bus.req_high = 1'b0; bus.ship_in = 1'b0; bus.ship_out = 1'b0;
      m_level = 0; m_last = SIDE_HIGH; held_low = 1'b0; held_high = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({bus.grant_low, bus.grant_high, bus.gate_low_open,
          bus.gate_high_open, bus.fill, bus.drain, bus.busy}), 0);
      chk("reset_level", int'(bus.level), 0);
      reset_n = 1'b1;

      // low-to-high passage from level 0
      trip(1, 1'b1, 1'b0, 1, 1, 0, 1'b0, g, n);
      chk("trip1_side", int'(g), int'(SIDE_LOW));
      chk("trip1_cycles", n, 13);
      @(posedge clk); #2;
      chk("trip1_level", int'(bus.level), 7);
      chk("trip1_busy", int'(bus.busy), 0);

      // tie after a low trip goes high; level already 7 so no drain in PREP
      trip(1, 1'b1, 1'b1, 2, 1, 0, 1'b0, g, n);
      chk("tie_after_low", int'(g), int'(SIDE_HIGH));
      chk("trip2_cycles", n, 14);
      held_low = 1'b0;

      // high request at level 0 with ship_in noise during PREP
      f0 = fill_seen;
      trip(2, 1'b0, 1'b1, 2, 2, 100, 1'b0, g, n);
      @(posedge clk); #2;
      chk("prep_fill_cycles", fill_seen - f0, 7);
      chk("trip3_level", int'(bus.level), 0);

      for (int t = 0; t < 25; t++) begin
         r = $urandom_range(2, 0);
         trip($urandom_range(3, 1), r != 1, r != 0, $urandom_range(4, 1), $urandom_range(4, 1),
              25, 1'b0, g, n);
      end

      // asynchronous reset while an exit gate is open
      held_low = 1'b0; held_high = 1'b0;
      r = $urandom_range(1, 0);
      trip(1, r == 0, r == 1, 1, 3, 0, 1'b1, g, n);
      @(posedge clk); #2;
      chk("exit_gate_open", int'(bus.gate_low_open | bus.gate_high_open), 1);
      bus.req_low = 1'b0; bus.req_high = 1'b0; bus.ship_in = 1'b0; bus.ship_out = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", int'({bus.grant_low, bus.grant_high, bus.gate_low_open,
          bus.gate_high_open, bus.fill, bus.drain, bus.busy}), 0);
      chk("async_reset_level", int'(bus.level), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_level = 0; m_last = SIDE_HIGH; held_low = 1'b0; held_high = 1'b0;

      trip(1, 1'b1, 1'b1, 1, 1, 10, 1'b0, g, n);
      chk("tie_after_reset", int'(g), int'(SIDE_LOW));
      for (int t = 0; t < 4; t++) begin
         r = $urandom_range(2, 0);
         trip($urandom_range(3, 1), r != 1, r != 0, $urandom_range(3, 1), $urandom_range(3, 1),
              25, 1'b0, g, n);
      end
      @(posedge clk); #2;
      chk("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/canal_lock_scheduler.md
CANAL_LOCK_SCHEDULER -- requirements
Module: canal_lock_scheduler

Interface
REQ-001 The block SHALL have parameter LEVEL_MAX, default 7: chamber water level at the high side, in steps; the low side is level 0.
REQ-002 The block SHALL have parameter LW, default $clog2(LEVEL_MAX+1): width of the level bus.
REQ-003 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port req_low, input, 1: ship waiting at the low gate (region 1); level signal, held until granted.
REQ-006 Port req_high, input, 1: ship waiting at the high gate (region 3); level signal, held until granted.
REQ-007 Port ship_in, input, 1: one-cycle pulse; the ship has fully entered the chamber.
REQ-008 Port ship_out, input, 1: one-cycle pulse; the ship has fully left the chamber.
REQ-009 Port grant_low / grant_high, output, 1 each: one-cycle pulse when that side's request is accepted.
REQ-010 Port gate_low_open / gate_high_open, output, 1 each: open command to the respective gate.
REQ-011 Port fill / drain, output, 1 each: raise or lower the water one step this cycle.
REQ-012 Port level, output, LW: current chamber water level.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, PREP, OPEN_ENTRY, CLOSE_ENTRY, TRANSFER, OPEN_EXIT, CLOSE_EXIT; all outputs are registered or Moore-decoded from state; no input reaches an output combinationally.
REQ-015 In IDLE, a request SHALL be granted when sampled high; the next state is PREP and the grant pulse is high for exactly that PREP-entry cycle.
REQ-016 Arbitration: if only one request is high, that side SHALL be granted; if both are high, the side not served last SHALL be granted (round-robin); after reset, low wins the first tie.
REQ-017 Entry side = granted side; exit side = the opposite side; target entry level = 0 (low) or LEVEL_MAX (high).
REQ-018 In PREP, if level differs from the entry level, fill or drain SHALL assert and level SHALL move one step per cycle; when level equals the entry level, the next state SHALL be OPEN_ENTRY with no pump asserted.
REQ-019 In OPEN_ENTRY, only the entry gate SHALL be open; on ship_in the next state SHALL be CLOSE_ENTRY (one cycle, both gates closed), then TRANSFER.
REQ-020 In TRANSFER, the level SHALL move one step per cycle toward the exit level; on reaching it, the next state SHALL be OPEN_EXIT.
REQ-021 In OPEN_EXIT, only the exit gate SHALL be open; on ship_out the next state SHALL be CLOSE_EXIT (one cycle), then IDLE; the last-served side is updated then.
REQ-022 Interlocks (invariants): gates never both open; no gate open while fill or drain is high; fill and drain never both high.
REQ-023 Level SHALL saturate: fill never asserts at LEVEL_MAX; drain never asserts at 0.
REQ-024 ship_in outside OPEN_ENTRY and ship_out outside OPEN_EXIT SHALL be ignored.
REQ-025 Requests arriving while busy SHALL NOT be granted until IDLE; they are not latched internally.
REQ-026 A request dropped before grant SHALL be forgotten; a request is not re-granted to the same ship.
REQ-027 Latency: from IDLE at level 0, req_low sampled at edge N gives grant_low in cycle N+1 and gate_low_open in cycle N+2.

Reset
REQ-028 While reset_n is low, the state SHALL be IDLE, level 0, last-served = high, and all outputs low, including mid-operation with a gate open.
REQ-029 After reset_n deasserts, the first grant SHALL occur no earlier than the first clock edge.

Structure
REQ-030 Package canal_pkg SHALL hold the lock_state_t enum and the side_t enum (SIDE_LOW, SIDE_HIGH); it is shared with controlMain.
REQ-031 One sub-module, water_level_counter (up/down saturating counter with fill/drain inputs), SHALL hold level.

Verification (LEVEL_MAX=7)
REQ-032 Reset; req_low=1 -> grant_low in cycle 1, gate_low_open in cycle 2, fill=0, level=0.
REQ-033 Full low-to-high trip: ship_in -> 1 closed cycle, then 7 fill cycles, level=7, gate_high_open; ship_out -> CLOSE_EXIT, then IDLE, busy=0.
REQ-034 Both requests high in IDLE after a served low trip -> grant_high; with level 7, gate_high_open follows with no drain.
REQ-035 req_high at level 0 -> 7 drain-free fill cycles in PREP before gate_high_open; ship_in pulsed during PREP is ignored.
REQ-036 reset_n low during OPEN_EXIT -> all outputs 0 and level=0 asynchronously; next tie goes to low.
REQ-037 A concurrent assertion checker SHALL verify the REQ-022/023 invariants hold across all scenarios.
